elapsed_sec_counter: RTL and testbench

- Seconds timer for the record/playback path. Counts elapsed whole seconds while a record or play session runs, and supports pause, resume, stop and saturation.
- Its 4-bit seconds value feeds the downstream two-digit seven-segment decoder directly; range 0..MAX_SEC.
- Status flags go to the top-level controller and LEDs.

---
 rtl/elapsed_sec_counter.sv | 107 ++++++++++
 tb/tb_elapsed_sec_counter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elapsed_sec_counter.sv
// Elapsed-seconds timer for record/playback sessions.
// Counts whole seconds in RUN; supports pause/resume, stop and saturation.
module elapsed_sec_counter #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned MAX_SEC       = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  output logic [3:0] o_sec,
  output logic       o_running,
  output logic       o_paused,
  output logic       o_full,
  output logic       o_tick
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] P_LAST =
    PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] SEC_MAX = 4'(MAX_SEC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        st, st_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0]    sec_n;
  logic          tick_n;

  always_comb begin
    st_n   = st;
    pre_n  = pre;
    sec_n  = o_sec;
    tick_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (i_start) begin
          st_n  = RUN;
          pre_n = '0;
          sec_n = '0;
        end
      end
      RUN: begin
        if (i_stop) begin
          st_n  = IDLE;
          pre_n = '0;
        end else if (i_pause) begin
          st_n = PAUSE;
        end else if (pre == P_LAST) begin
          pre_n  = '0;
          sec_n  = o_sec + 4'd1;
          tick_n = 1'b1;
          if (sec_n == SEC_MAX)
            st_n = DONE;
        end else begin
          pre_n = pre + PW'(1);
        end
      end
      PAUSE: begin
        if (i_stop) begin
          st_n  = IDLE;
          pre_n = '0;
        end else if (i_start || i_pause) begin
          st_n = RUN;
        end
      end
      DONE: begin
        if (i_stop) begin
          st_n  = IDLE;
          pre_n = '0;
        end else if (i_start) begin
          st_n  = RUN;
          pre_n = '0;
          sec_n = '0;
        end
      end
    endcase
  end

  // Flags are taken from the next state so they move on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st        <= IDLE;
      pre       <= '0;
      o_sec     <= '0;
      o_tick    <= 1'b0;
      o_running <= 1'b0;
      o_paused  <= 1'b0;
      o_full    <= 1'b0;
    end else begin
      st        <= st_n;
      pre       <= pre_n;
      o_sec     <= sec_n;
      o_tick    <= tick_n;
      o_running <= (st_n == RUN);
      o_paused  <= (st_n == PAUSE);
      o_full    <= (st_n == DONE);
    end
  end

endmodule

// File: tb/tb_elapsed_sec_counter.sv
// Bench for elapsed_sec_counter: two parameterisations driven together,
// checked against a run-cycle-count model plus literal expectations.
module tb_elapsed_sec_counter;

  localparam int TA = 4;
  localparam int MA = 15;
  localparam int TB = 2;
  localparam int MB = 9;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;

  logic [3:0] sec_a, sec_b;
  logic run_a, run_b, pau_a, pau_b;
  logic full_a, full_b, tick_a, tick_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elapsed_sec_counter #(
    .TICKS_PER_SEC(TA),
    .MAX_SEC(MA)
  ) dut_a (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_pause(pause),
    .i_stop(stop),
    .o_sec(sec_a),
    .o_running(run_a),
    .o_paused(pau_a),
    .o_full(full_a),
    .o_tick(tick_a)
  );

  elapsed_sec_counter #(
    .TICKS_PER_SEC(TB),
    .MAX_SEC(MB)
  ) dut_b (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_pause(pause),
    .i_stop(stop),
    .o_sec(sec_b),
    .o_running(run_b),
    .o_paused(pau_b),
    .o_full(full_b),
    .o_tick(tick_b)
  );

  // Model: seconds = RUN cycles in this session / ticks, capped.
  typedef struct {
    int mode;
    int run;
    int sec;
    bit tick;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = M_IDLE;
    m.run  = 0;
    m.sec  = 0;
    m.tick = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int t, int mx,
                                 bit st, bit pa, bit sp);
    mdl_t r;
    r = m;
    r.tick = 1'b0;
    case (m.mode)
      M_IDLE: if (st) begin
        r.mode = M_RUN;
        r.run  = 0;
        r.sec  = 0;
      end
      M_RUN: begin
        if (sp) r.mode = M_IDLE;
        else if (pa) r.mode = M_PAUSE;
        else begin
          r.run = m.run + 1;
          if (r.run / t > m.sec) begin
            r.sec  = r.run / t;
            r.tick = 1'b1;
            if (r.sec == mx) r.mode = M_DONE;
          end
        end
      end
      M_PAUSE: begin
        if (sp) r.mode = M_IDLE;
        else if (st || pa) r.mode = M_RUN;
      end
      default: begin
        if (sp) r.mode = M_IDLE;
        else if (st) begin
          r.mode = M_RUN;
          r.run  = 0;
          r.sec  = 0;
        end
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, TA, MA, start, pause, stop);
      mb <= mstep(mb, TB, MB, start, pause, stop);
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_all(string tag);
    chk({tag, " a.sec"}, int'(sec_a), ma.sec);
    chk({tag, " a.run"}, int'(run_a), int'(ma.mode == M_RUN));
    chk({tag, " a.pau"}, int'(pau_a), int'(ma.mode == M_PAUSE));
    chk({tag, " a.full"}, int'(full_a), int'(ma.mode == M_DONE));
    chk({tag, " a.tick"}, int'(tick_a), int'(ma.tick));
    chk({tag, " b.sec"}, int'(sec_b), mb.sec);
    chk({tag, " b.run"}, int'(run_b), int'(mb.mode == M_RUN));
    chk({tag, " b.pau"}, int'(pau_b), int'(mb.mode == M_PAUSE));
    chk({tag, " b.full"}, int'(full_b), int'(mb.mode == M_DONE));
    chk({tag, " b.tick"}, int'(tick_b), int'(mb.tick));
  endtask

  always @(negedge clk) cmp_all("cyc");

  task automatic step(bit st, bit pa, bit sp);
    start = st;
    pause = pa;
    stop  = sp;
    @(negedge clk);
    #1;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  int ticks;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst sec", int'(sec_a), 0);
    chk("rst run", int'(run_a), 0);
    rst_n = 1'b1;
    #1;
    idle(2);
    chk("idle sec", int'(sec_a), 0);

    step(1'b1, 1'b0, 1'b0);
    chk("t1 run", int'(run_a), 1);
    chk("t1 sec0", int'(sec_a), 0);
    idle(3);
    chk("t1 sec@3", int'(sec_a), 0);
    idle(1);
    chk("t1 sec@4", int'(sec_a), 1);
    chk("t1 tick@4", int'(tick_a), 1);
    idle(8);
    chk("t1 sec@12", int'(sec_a), 3);
    chk("t1 b.sec@12", int'(sec_b), 6);

    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    chk("t2 sec@6", int'(sec_a), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("t2 paused", int'(pau_a), 1);
    idle(20);
    chk("t2 hold sec", int'(sec_a), 1);
    chk("t2 hold pau", int'(pau_a), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("t2 resumed", int'(run_a), 1);
    idle(1);
    chk("t2 sec+1", int'(sec_a), 1);
    idle(1);
    chk("t2 sec+2", int'(sec_a), 2);

    idle(52);
    chk("t3 sec15", int'(sec_a), 15);
    chk("t3 full", int'(full_a), 1);
    chk("t3 run0", int'(run_a), 0);
    ticks = 0;
    repeat (40) begin
      idle(1);
      ticks += int'(tick_a);
    end
    chk("t3 no tick", ticks, 0);
    chk("t3 sat sec", int'(sec_a), 15);
    step(1'b0, 1'b0, 1'b1);
    chk("t3 stop sec", int'(sec_a), 15);
    chk("t3 stop full", int'(full_a), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("t3 restart sec", int'(sec_a), 0);
    chk("t3 restart run", int'(run_a), 1);

    idle(5);
    step(1'b1, 1'b0, 1'b1);
    chk("t4 stop>start run", int'(run_a), 0);
    chk("t4 stop>start sec", int'(sec_a), 1);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    chk("t4 pause@3", int'(pau_a), 1);
    chk("t4 pause sec", int'(sec_a), 0);
    chk("t4 pause tick", int'(tick_a), 0);
    step(1'b0, 1'b1, 1'b0);
    idle(25);
    chk("t5 sec7", int'(sec_a), 7);

    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 async sec", int'(sec_a), 0);
    chk("t5 async run", int'(run_a), 0);
    chk("t5 async tick", int'(tick_a), 0);
    chk("t5 async b.sec", int'(sec_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle(5);
    chk("t5 stay idle", int'(run_a), 0);
    chk("t5 idle sec", int'(sec_a), 0);

    step(1'b1, 1'b0, 1'b0);
    idle(17);
    chk("t6 b.full@17", int'(full_b), 0);
    chk("t6 b.sec@17", int'(sec_b), 8);
    idle(1);
    chk("t6 b.full@18", int'(full_b), 1);
    chk("t6 b.sec@18", int'(sec_b), 9);

    repeat (3000) begin
      automatic int r = int'($urandom_range(0, 99));
      step(r < 4, r >= 4 && r < 9, r >= 9 && r < 11);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
